// File: rtl/des_pkg.sv
// Shared DES definitions for the encrypt and decrypt blocks: permutation tables,
// S-boxes, the decrypt key-rotate schedule, mode codes, FSM state type and helpers.
package des_pkg;

  localparam logic [2:0] MODE_ECB = 3'b000;
  localparam logic [2:0] MODE_CBC = 3'b001;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ROUND,
    ST_DONE
  } des_state_t;

  // Tables use DES 1-based bit numbering, bit 1 being the MSB.
  localparam int IP_TBL [64] = '{
    58, 50, 42, 34, 26, 18, 10,  2,
    60, 52, 44, 36, 28, 20, 12,  4,
    62, 54, 46, 38, 30, 22, 14,  6,
    64, 56, 48, 40, 32, 24, 16,  8,
    57, 49, 41, 33, 25, 17,  9,  1,
    59, 51, 43, 35, 27, 19, 11,  3,
    61, 53, 45, 37, 29, 21, 13,  5,
    63, 55, 47, 39, 31, 23, 15,  7
  };

  localparam int FP_TBL [64] = '{
    40,  8, 48, 16, 56, 24, 64, 32,
    39,  7, 47, 15, 55, 23, 63, 31,
    38,  6, 46, 14, 54, 22, 62, 30,
    37,  5, 45, 13, 53, 21, 61, 29,
    36,  4, 44, 12, 52, 20, 60, 28,
    35,  3, 43, 11, 51, 19, 59, 27,
    34,  2, 42, 10, 50, 18, 58, 26,
    33,  1, 41,  9, 49, 17, 57, 25
  };

  localparam int E_TBL [48] = '{
    32,  1,  2,  3,  4,  5,
     4,  5,  6,  7,  8,  9,
     8,  9, 10, 11, 12, 13,
    12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21,
    20, 21, 22, 23, 24, 25,
    24, 25, 26, 27, 28, 29,
    28, 29, 30, 31, 32,  1
  };

  localparam int P_TBL [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,
     1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9,
    19, 13, 30,  6, 22, 11,  4, 25
  };

  localparam int PC1_TBL [56] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4
  };

  localparam int PC2_TBL [48] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };

  // Right-rotate amounts applied to C/D before PC2 in decrypt round j=1..16.
  localparam int ROT_SCHED [16] = '{0, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  // Indexed as box*64 + row*16 + col.
  localparam int SBOX [512] = '{
    14,  4, 13,  1,  2, 15, 11,  8,  3, 10,  6, 12,  5,  9,  0,  7,
     0, 15,  7,  4, 14,  2, 13,  1, 10,  6, 12, 11,  9,  5,  3,  8,
     4,  1, 14,  8, 13,  6,  2, 11, 15, 12,  9,  7,  3, 10,  5,  0,
    15, 12,  8,  2,  4,  9,  1,  7,  5, 11,  3, 14, 10,  0,  6, 13,
    15,  1,  8, 14,  6, 11,  3,  4,  9,  7,  2, 13, 12,  0,  5, 10,
     3, 13,  4,  7, 15,  2,  8, 14, 12,  0,  1, 10,  6,  9, 11,  5,
     0, 14,  7, 11, 10,  4, 13,  1,  5,  8, 12,  6,  9,  3,  2, 15,
    13,  8, 10,  1,  3, 15,  4,  2, 11,  6,  7, 12,  0,  5, 14,  9,
    10,  0,  9, 14,  6,  3, 15,  5,  1, 13, 12,  7, 11,  4,  2,  8,
    13,  7,  0,  9,  3,  4,  6, 10,  2,  8,  5, 14, 12, 11, 15,  1,
    13,  6,  4,  9,  8, 15,  3,  0, 11,  1,  2, 12,  5, 10, 14,  7,
     1, 10, 13,  0,  6,  9,  8,  7,  4, 15, 14,  3, 11,  5,  2, 12,
     7, 13, 14,  3,  0,  6,  9, 10,  1,  2,  8,  5, 11, 12,  4, 15,
    13,  8, 11,  5,  6, 15,  0,  3,  4,  7,  2, 12,  1, 10, 14,  9,
    10,  6,  9,  0, 12, 11,  7, 13, 15,  1,  3, 14,  5,  2,  8,  4,
     3, 15,  0,  6, 10,  1, 13,  8,  9,  4,  5, 11, 12,  7,  2, 14,
     2, 12,  4,  1,  7, 10, 11,  6,  8,  5,  3, 15, 13,  0, 14,  9,
    14, 11,  2, 12,  4,  7, 13,  1,  5,  0, 15, 10,  3,  9,  8,  6,
     4,  2,  1, 11, 10, 13,  7,  8, 15,  9, 12,  5,  6,  3,  0, 14,
    11,  8, 12,  7,  1, 14,  2, 13,  6, 15,  0,  9, 10,  4,  5,  3,
    12,  1, 10, 15,  9,  2,  6,  8,  0, 13,  3,  4, 14,  7,  5, 11,
    10, 15,  4,  2,  7, 12,  9,  5,  6,  1, 13, 14,  0, 11,  3,  8,
     9, 14, 15,  5,  2,  8, 12,  3,  7,  0,  4, 10,  1, 13, 11,  6,
     4,  3,  2, 12,  9,  5, 15, 10, 11, 14,  1,  7,  6,  0,  8, 13,
     4, 11,  2, 14, 15,  0,  8, 13,  3, 12,  9,  7,  5, 10,  6,  1,
    13,  0, 11,  7,  4,  9,  1, 10, 14,  3,  5, 12,  2, 15,  8,  6,
     1,  4, 11, 13, 12,  3,  7, 14, 10, 15,  6,  8,  0,  5,  9,  2,
     6, 11, 13,  8,  1,  4, 10,  7,  9,  5,  0, 15, 14,  2,  3, 12,
    13,  2,  8,  4,  6, 15, 11,  1, 10,  9,  3, 14,  5,  0, 12,  7,
     1, 15, 13,  8, 10,  3,  7,  4, 12,  5,  6, 11,  0, 14,  9,  2,
     7, 11,  4,  1,  9, 12, 14,  2,  0,  6, 10, 13, 15,  3,  5,  8,
     2,  1, 14,  7,  4, 10,  8, 13, 15, 12,  9,  0,  3,  5,  6, 11
  };

  function automatic logic [63:0] perm_ip(input logic [63:0] x);
    logic [63:0] y;
    y = '0;
    for (int unsigned i = 0; i < 64; i++) y[6'(63 - i)] = x[6'(64 - IP_TBL[i])];
    return y;
  endfunction

  function automatic logic [63:0] perm_fp(input logic [63:0] x);
    logic [63:0] y;
    y = '0;
    for (int unsigned i = 0; i < 64; i++) y[6'(63 - i)] = x[6'(64 - FP_TBL[i])];
    return y;
  endfunction

  function automatic logic [47:0] perm_e(input logic [31:0] x);
    logic [47:0] y;
    y = '0;
    for (int unsigned i = 0; i < 48; i++) y[6'(47 - i)] = x[5'(32 - E_TBL[i])];
    return y;
  endfunction

  function automatic logic [31:0] perm_p(input logic [31:0] x);
    logic [31:0] y;
    y = '0;
    for (int unsigned i = 0; i < 32; i++) y[5'(31 - i)] = x[5'(32 - P_TBL[i])];
    return y;
  endfunction

  function automatic logic [55:0] perm_pc1(input logic [63:0] x);
    logic [55:0] y;
    y = '0;
    for (int unsigned i = 0; i < 56; i++) y[6'(55 - i)] = x[6'(64 - PC1_TBL[i])];
    return y;
  endfunction

  function automatic logic [47:0] perm_pc2(input logic [55:0] x);
    logic [47:0] y;
    y = '0;
    for (int unsigned i = 0; i < 48; i++) y[6'(47 - i)] = x[6'(56 - PC2_TBL[i])];
    return y;
  endfunction

  function automatic logic [31:0] sbox_all(input logic [47:0] x);
    logic [31:0] y;
    logic [5:0]  six;
    logic [1:0]  row;
    logic [3:0]  col;
    y = '0;
    for (int unsigned s = 0; s < 8; s++) begin
      six = x[6'(42 - 6 * s) +: 6];
      row = {six[5], six[0]};
      col = six[4:1];
      y[5'(28 - 4 * s) +: 4] = 4'(SBOX[9'(64 * s + 16 * row + col)]);
    end
    return y;
  endfunction

  function automatic logic [27:0] rotr28(input logic [27:0] v, input int n);
    case (n)
      1:       return {v[0], v[27:1]};
      2:       return {v[1:0], v[27:2]};
      default: return v;
    endcase
  endfunction

endpackage

// File: rtl/des_round.sv
// One combinational DES Feistel round: L' = R, R' = L ^ P(S(E(R) ^ K)).
module des_round
  import des_pkg::*;
(
  input  logic [31:0] l,
  input  logic [31:0] r,
  input  logic [47:0] subkey,
  output logic [31:0] l_next,
  output logic [31:0] r_next
);

  logic [31:0] f_out;

  always_comb begin
    f_out  = perm_p(sbox_all(perm_e(r) ^ subkey));
    l_next = r;
    r_next = l ^ f_out;
  end

endmodule

// File: rtl/des_dec_block.sv
// Iterative DES decryption, one round per clock, with ECB and CBC chaining.
module des_dec_block
  import des_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] cipher,
  input  logic        cipher_en,
  input  logic [63:0] key,
  input  logic [2:0]  mode,
  input  logic [63:0] iv,
  input  logic        iv_update,
  output logic [63:0] plain,
  output logic        plain_rdy,
  output logic        busy
);

  des_state_t  state, state_nx;
  logic [3:0]  cnt;
  logic [31:0] l_q, r_q, l_nx, r_nx;
  logic [27:0] c_q, d_q, c_rot, d_rot;
  logic [47:0] subkey;
  logic [63:0] chain_q, cblk_q, ip_in, fp_out;
  logic [55:0] pc1_key;
  logic [2:0]  mode_q;

  // C/D start at PC1(key) = C16/D16, so round 1 needs no rotate and the
  // schedule walks the key back one subkey per round.
  always_comb begin
    ip_in   = perm_ip(cipher);
    pc1_key = perm_pc1(key);
    c_rot   = rotr28(c_q, ROT_SCHED[cnt]);
    d_rot   = rotr28(d_q, ROT_SCHED[cnt]);
    subkey  = perm_pc2({c_rot, d_rot});
    fp_out  = perm_fp({r_q, l_q});
  end

  des_round u_round (
    .l      (l_q),
    .r      (r_q),
    .subkey (subkey),
    .l_next (l_nx),
    .r_next (r_nx)
  );

  always_comb begin
    state_nx = state;
    busy     = (state != ST_IDLE);
    case (state)
      ST_IDLE:  if (cipher_en) state_nx = ST_ROUND;
      ST_ROUND: if (cnt == 4'd15) state_nx = ST_DONE;
      ST_DONE:  state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      l_q       <= '0;
      r_q       <= '0;
      c_q       <= '0;
      d_q       <= '0;
      chain_q   <= '0;
      cblk_q    <= '0;
      mode_q    <= MODE_ECB;
      plain     <= '0;
      plain_rdy <= 1'b0;
    end else begin
      state     <= state_nx;
      plain_rdy <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (iv_update) chain_q <= iv;
          if (cipher_en) begin
            {l_q, r_q} <= ip_in;
            {c_q, d_q} <= pc1_key;
            cblk_q     <= cipher;
            mode_q     <= mode;
            cnt        <= '0;
          end
        end
        ST_ROUND: begin
          l_q <= l_nx;
          r_q <= r_nx;
          c_q <= c_rot;
          d_q <= d_rot;
          cnt <= cnt + 4'd1;
        end
        ST_DONE: begin
          plain_rdy <= 1'b1;
          if (mode_q == MODE_CBC) begin
            plain   <= fp_out ^ chain_q;
            chain_q <= cblk_q;
          end else begin
            plain <= fp_out;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_des_dec_block.sv
// Directed bench for des_dec_block: known-answer vectors plus chaining, busy and reset sequences.
module tb_des_dec_block;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] cipher;
  logic        cipher_en;
  logic [63:0] key;
  logic [2:0]  mode;
  logic [63:0] iv;
  logic        iv_update;
  logic [63:0] plain;
  logic        plain_rdy;
  logic        busy;

  int errors = 0;
  int checks = 0;

  localparam logic [63:0] KEY1 = 64'h133457799BBCDFF1;
  localparam logic [63:0] CT1  = 64'h85E813540F0AB405;
  localparam logic [63:0] PT1  = 64'h0123456789ABCDEF;
  localparam logic [63:0] KEY2 = 64'h0E329232EA6D0D73;
  localparam logic [63:0] CT2  = 64'h0000000000000000;
  localparam logic [63:0] PT2  = 64'h8787878787878787;

  des_dec_block dut (
    .clk       (clk),
    .rst       (rst),
    .cipher    (cipher),
    .cipher_en (cipher_en),
    .key       (key),
    .mode      (mode),
    .iv        (iv),
    .iv_update (iv_update),
    .plain     (plain),
    .plain_rdy (plain_rdy),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] key;
    logic [63:0] cipher;
    logic [2:0]  mode;
    logic        ivu;
    logic [63:0] iv;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Called at #1 after a rising edge with the DUT idle; returns at #1 after the
  // edge on which plain_rdy was seen. poke_at>0 fires a foreign request+iv_update at edge E<poke_at>.
  task automatic run_block(input logic [63:0] k, input logic [63:0] c, input logic [2:0] m,
                           input logic ivu, input logic [63:0] ivv, input int poke_at,
                           output logic [63:0] res, output int lat, output int busy_n);
    key = k; cipher = c; mode = m; iv_update = ivu; iv = ivv; cipher_en = 1'b1;
    @(posedge clk); #1;
    key    = {$urandom, $urandom};
    cipher = {$urandom, $urandom};
    mode   = 3'($urandom);
    iv     = {$urandom, $urandom};
    busy_n = busy ? 1 : 0;
    lat    = 0;
    res    = '0;
    while (lat < 40) begin
      if (poke_at > 0 && lat == poke_at - 1) begin
        cipher_en = 1'b1; iv_update = 1'b1; iv = '1; cipher = ~c; key = ~k;
      end else begin
        cipher_en = 1'b0; iv_update = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
      if (plain_rdy) begin
        res = plain;
        break;
      end
      if (busy) busy_n++;
    end
    cipher_en = 1'b0;
    iv_update = 1'b0;
  endtask

  logic [63:0] res;
  int lat, bsy, rdy_n;

  initial begin
    vecs[0] = '{KEY1, CT1, 3'b000, 1'b0, 64'h0, PT1};
    vecs[1] = '{KEY2, CT2, 3'b000, 1'b0, 64'h0, PT2};
    vecs[2] = '{KEY1, CT1, 3'b110, 1'b0, 64'h0, PT1};
    vecs[3] = '{KEY1, CT1, 3'b001, 1'b1, PT1,   64'h0};
    vecs[4] = '{KEY1, CT1, 3'b001, 1'b0, 64'h0, 64'h84CB563386A179EA};
    vecs[5] = '{KEY2, CT2, 3'b001, 1'b1, 64'h0, PT2};
    vecs[6] = '{KEY1, CT1, 3'b000, 1'b0, 64'h0, PT1};
    vecs[7] = '{KEY2, CT2, 3'b001, 1'b0, 64'h0, PT2};

    rst = 1'b1; cipher = '0; cipher_en = 1'b0; key = '0; mode = '0; iv = '0; iv_update = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_plain", plain, 64'h0);
    chk("reset_rdy", {63'h0, plain_rdy}, 64'h0);
    chk("reset_busy", {63'h0, busy}, 64'h0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("idle_busy", {63'h0, busy}, 64'h0);

    for (int i = 0; i < 8; i++) begin
      run_block(vecs[i].key, vecs[i].cipher, vecs[i].mode, vecs[i].ivu, vecs[i].iv, 0, res, lat, bsy);
      chk($sformatf("vec%0d_plain", i), res, vecs[i].exp);
      chk($sformatf("vec%0d_latency", i), 64'(lat), 64'd17);
      chk($sformatf("vec%0d_busy_cycles", i), 64'(bsy), 64'd17);
      @(posedge clk); #1;
      chk($sformatf("vec%0d_rdy_drop", i), {63'h0, plain_rdy}, 64'h0);
      chk($sformatf("vec%0d_plain_hold", i), plain, vecs[i].exp);
    end

    // CBC chaining from a zero IV; iv_update during the second block must be ignored.
    run_block(KEY1, CT1, 3'b001, 1'b1, 64'h0, 0, res, lat, bsy);
    chk("cbc_first", res, PT1);
    run_block(KEY1, CT1, 3'b001, 1'b0, 64'h0, 7, res, lat, bsy);
    chk("cbc_second", res, 64'h84CB563386A179EA);
    chk("cbc_second_latency", 64'(lat), 64'd17);
    @(posedge clk); #1;

    // Busy rejection at E5, then back-to-back accept at E18.
    run_block(KEY1, CT1, 3'b000, 1'b0, 64'h0, 5, res, lat, bsy);
    chk("rej_plain", res, PT1);
    chk("rej_latency", 64'(lat), 64'd17);
    chk("rej_busy_cycles", 64'(bsy), 64'd17);
    run_block(KEY2, CT2, 3'b000, 1'b0, 64'h0, 0, res, lat, bsy);
    chk("b2b_plain", res, PT2);
    chk("b2b_latency", 64'(lat), 64'd17);
    chk("b2b_busy_cycles", 64'(bsy), 64'd17);
    @(posedge clk); #1;
    chk("b2b_rdy_drop", {63'h0, plain_rdy}, 64'h0);

    // Reset at E8 aborts a CBC block and clears the chain.
    run_block(KEY1, CT1, 3'b001, 1'b1, 64'h0, 0, res, lat, bsy);
    chk("pre_reset_cbc", res, PT1);
    @(posedge clk); #1;
    key = KEY1; cipher = CT1; mode = 3'b001; cipher_en = 1'b1;
    @(posedge clk); #1;
    cipher_en = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_plain", plain, 64'h0);
    chk("abort_busy", {63'h0, busy}, 64'h0);
    rdy_n = 0; bsy = 0;
    repeat (25) begin
      @(posedge clk); #1;
      if (plain_rdy) rdy_n++;
      if (busy) bsy++;
    end
    chk("abort_rdy_count", 64'(rdy_n), 64'd0);
    chk("abort_busy_count", 64'(bsy), 64'd0);
    run_block(KEY1, CT1, 3'b001, 1'b0, 64'h0, 0, res, lat, bsy);
    chk("post_reset_cbc", res, PT1);
    chk("post_reset_latency", 64'(lat), 64'd17);
    run_block(KEY2, CT2, 3'b000, 1'b0, 64'h0, 0, res, lat, bsy);
    chk("post_reset_ecb", res, PT2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
